// File: rtl/div_unit.sv
// Iterative signed restoring divider (one quotient bit per cycle) for the DIV instruction.
// Optional `DIV_EARLY_EXIT_EN` skips the iteration when |a| < |b|.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             DivOut,
    output logic             divZero,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_FIX  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ZERO = 3'd4;

    logic [2:0]       state_reg;
    logic             divctrl_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] bmag_reg;
    logic [CW-1:0]    cnt_reg;
    logic             sa_reg;
    logic             sb_reg;

    logic             start;
    logic [WIDTH-1:0] amag;
    logic [WIDTH-1:0] bmag_in;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;

    assign start   = DivCtrl && !divctrl_reg && (state_reg == S_IDLE);
    assign amag    = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign bmag_in = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign busy    = (state_reg != S_IDLE);

    // Partial remainder can reach 2*|b|-1, so the compare needs one extra bit;
    // a clear top bit of the difference means rem >= |b|.
    assign rem_shift = {rem_reg, q_reg[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, bmag_reg};
    assign rem_ge    = ~rem_diff[WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            divctrl_reg <= 1'b0;
            q_reg       <= '0;
            rem_reg     <= '0;
            bmag_reg    <= '0;
            cnt_reg     <= '0;
            sa_reg      <= 1'b0;
            sb_reg      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            DivOut      <= 1'b0;
            divZero     <= 1'b0;
        end else begin
            divctrl_reg <= DivCtrl;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            divZero   <= 1'b1;
                            state_reg <= S_ZERO;
                        end else begin
                            sa_reg    <= a[WIDTH-1];
                            sb_reg    <= b[WIDTH-1];
                            bmag_reg  <= bmag_in;
                            rem_reg   <= '0;
                            q_reg     <= amag;
                            cnt_reg   <= CW'(WIDTH);
                            state_reg <= S_RUN;
`ifdef DIV_EARLY_EXIT_EN
                            if (amag < bmag_in) begin
                                q_reg     <= '0;
                                rem_reg   <= amag;
                                state_reg <= S_FIX;
                            end
`endif
                        end
                    end
                end
                S_RUN: begin
                    q_reg   <= {q_reg[WIDTH-2:0], rem_ge};
                    rem_reg <= rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    lo        <= (sa_reg ^ sb_reg) ? (~q_reg + 1'b1) : q_reg;
                    hi        <= sa_reg ? (~rem_reg + 1'b1) : rem_reg;
                    DivOut    <= 1'b1;
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    DivOut    <= 1'b0;
                    state_reg <= S_IDLE;
                end
                S_ZERO: begin
                    divZero   <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: signed results, latency, divide-by-zero, held start, mid-op reset.
module tb_div_unit;
    logic        clk;
    logic        reset;
    logic        DivCtrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        DivOut;
    logic        divZero;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .DivCtrl (DivCtrl),
        .a       (a),
        .b       (b),
        .hi      (hi),
        .lo      (lo),
        .DivOut  (DivOut),
        .divZero (divZero),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Issue one start edge, then scramble a/b to show they are sampled only at start.
    // lat = number of edges after the start edge before DivOut/divZero is seen (-1 = never).
    task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input bit hold,
                           output int lat, output bit done_seen, output bit zero_seen,
                           output bit busy0);
        @(negedge clk);
        a = av;
        b = bv;
        DivCtrl = 1'b1;
        @(posedge clk);
        #1;
        busy0 = busy;
        if (!hold) DivCtrl = 1'b0;
        a = ~av;
        b = 32'h0;
        lat = -1;
        done_seen = 1'b0;
        zero_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (DivOut || divZero) begin
                lat = i;
                done_seen = DivOut;
                zero_seen = divZero;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Full operation with result, latency and pulse-width checks.
    task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input bit hold, input int exp_lat,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int lat;
        bit dn;
        bit zr;
        bit b0;
        run_div(av, bv, hold, lat, dn, zr, b0);
        check_eq({tag, " busy_after_start"}, 32'(b0), 32'd1);
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " divZero"}, 32'(zr), 32'd0);
        check_eq({tag, " lo"}, lo, exp_lo);
        check_eq({tag, " hi"}, hi, exp_hi);
        @(posedge clk);
        #1;
        check_eq({tag, " DivOut_one_cycle"}, 32'(DivOut), 32'd0);
        check_eq({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (DivOut || busy) seen = 1'b1;
        end
        check_eq({tag, " no_activity"}, 32'(seen), 32'd0);
    endtask

    localparam int FULL_LAT = 33;
`ifdef DIV_EARLY_EXIT_EN
    localparam int SMALL_LAT = 1;
`else
    localparam int SMALL_LAT = 33;
`endif

    initial begin
        int lat;
        bit dn;
        bit zr;
        bit b0;

        reset = 1'b0;
        DivCtrl = 1'b0;
        a = 32'h0;
        b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst hi", hi, 32'h0);
        check_eq("rst lo", lo, 32'h0);
        check_eq("rst DivOut", 32'(DivOut), 32'd0);
        check_eq("rst divZero", 32'(divZero), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        do_div("7/2", 32'd7, 32'd2, 1'b0, FULL_LAT, 32'd3, 32'd1);
        do_div("-7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, FULL_LAT, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div("7/-2", 32'd7, 32'hFFFF_FFFE, 1'b0, FULL_LAT, 32'hFFFF_FFFD, 32'd1);
        do_div("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, FULL_LAT, 32'd14, 32'hFFFF_FFFE);

        // Preload 7/2, then divide by zero: flag for one cycle, results untouched.
        do_div("preload 7/2", 32'd7, 32'd2, 1'b0, FULL_LAT, 32'd3, 32'd1);
        run_div(32'd5, 32'd0, 1'b0, lat, dn, zr, b0);
        check_eq("5/0 divZero_latency", 32'(lat), 32'd0);
        check_eq("5/0 divZero_seen", 32'(zr), 32'd1);
        @(posedge clk);
        #1;
        check_eq("5/0 divZero_one_cycle", 32'(divZero), 32'd0);
        check_eq("5/0 idle_after", 32'(busy), 32'd0);
        watch_no_done("5/0", 40);
        check_eq("5/0 hi_kept", hi, 32'd1);
        check_eq("5/0 lo_kept", lo, 32'd3);

        // Overflow case with DivCtrl held high: no retrigger afterwards.
        do_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, FULL_LAT, 32'h8000_0000, 32'h0);
        watch_no_done("held DivCtrl", 40);
        @(negedge clk);
        DivCtrl = 1'b0;

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        DivCtrl = 1'b1;
        @(posedge clk);
        #1;
        DivCtrl = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("midrst hi", hi, 32'h0);
        check_eq("midrst lo", lo, 32'h0);
        check_eq("midrst busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        watch_no_done("after midrst", 40);
        do_div("100/7", 32'd100, 32'd7, 1'b0, FULL_LAT, 32'd14, 32'd2);

        do_div("3/10", 32'd3, 32'd10, 1'b0, SMALL_LAT, 32'd0, 32'd3);
        do_div("-3/10", 32'hFFFF_FFFD, 32'd10, 1'b0, SMALL_LAT, 32'd0, 32'hFFFF_FFFD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
